// File: rtl/kyber_io_loader.sv
// Word-serial loader that assembles the wide Kyber operand registers from a narrow stream.
// Optional build macro KYBER_LOADER_ZEROIZE_EN clears secret operands after use or on a framing error.
module kyber_io_loader #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_mode,
  output logic              cmd_ready,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic [1:0]        mode,
  output logic              start,
  output logic [255:0]      random_coin,
  output logic [255:0]      m_in,
  output logic [6399:0]     pk_in,
  output logic [6143:0]     sk_in,
  output logic [6143:0]     c_in,
  input  logic              core_finish,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned W256 = 256 / WORD_W;
  localparam int unsigned WPK  = 6400 / WORD_W;
  localparam int unsigned WSK  = 6144 / WORD_W;

  localparam logic [8:0] LAST_KG  = 9'(W256 - 1);
  localparam logic [8:0] LAST_ENC = 9'(2 * W256 + WPK - 1);
  localparam logic [8:0] LAST_DEC = 9'(2 * WSK - 1);
  localparam logic [8:0] ENC_RC   = 9'(W256);
  localparam logic [8:0] ENC_PK   = 9'(2 * W256);
  localparam logic [8:0] DEC_SK   = 9'(WSK);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FIRE, ST_WAIT} state_t;
  typedef enum logic [2:0] {FLD_NONE, FLD_RC, FLD_M, FLD_PK, FLD_C, FLD_SK} fld_t;

  state_t      state, state_nxt;
  fld_t        wr_fld;
  logic [8:0]  cnt;
  logic [8:0]  wr_off;
  logic [12:0] wr_bit;
  logic [8:0]  last_idx;
  logic        cmd_acc, word_acc, is_last, frame_ok, frame_err, finish_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    cmd_ready  = (state == ST_IDLE);
    s_ready    = (state == ST_LOAD);
    busy       = (state != ST_IDLE);
    start      = (state == ST_FIRE);
    cmd_acc    = cmd_valid & cmd_ready;
    word_acc   = s_valid & s_ready;
    unique case (mode)
      2'd0:    last_idx = LAST_KG;
      2'd1:    last_idx = LAST_ENC;
      default: last_idx = LAST_DEC;
    endcase
    is_last    = (cnt == last_idx);
    frame_ok   = word_acc & s_last & is_last;
    // An early s_last and a missing s_last on the final word are the same fault
    frame_err  = word_acc & (s_last != is_last);
    finish_acc = (state == ST_WAIT) & core_finish;

    state_nxt = state;
    unique case (state)
      ST_IDLE: if (cmd_acc && cmd_mode != 2'd3) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (frame_ok)       state_nxt = ST_FIRE;
        else if (frame_err) state_nxt = ST_IDLE;
      end
      ST_FIRE: state_nxt = ST_WAIT;
      ST_WAIT: if (core_finish) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Map the running word count onto the field and word offset for the latched mode
  always_comb begin
    wr_fld = FLD_NONE;
    wr_off = cnt;
    unique case (mode)
      2'd0: wr_fld = FLD_RC;
      2'd1: begin
        if (cnt < ENC_RC) begin
          wr_fld = FLD_M;
        end else if (cnt < ENC_PK) begin
          wr_fld = FLD_RC;
          wr_off = cnt - ENC_RC;
        end else begin
          wr_fld = FLD_PK;
          wr_off = cnt - ENC_PK;
        end
      end
      2'd2: begin
        if (cnt < DEC_SK) begin
          wr_fld = FLD_C;
        end else begin
          wr_fld = FLD_SK;
          wr_off = cnt - DEC_SK;
        end
      end
      default: wr_fld = FLD_NONE;
    endcase
    wr_bit = 13'(wr_off * WORD_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      mode        <= '0;
      err         <= 1'b0;
      done        <= 1'b0;
      random_coin <= '0;
      m_in        <= '0;
      pk_in       <= '0;
      sk_in       <= '0;
      c_in        <= '0;
    end else begin
      done <= finish_acc;
      if (cmd_acc) begin
        mode <= cmd_mode;
        cnt  <= '0;
        err  <= (cmd_mode == 2'd3);
      end
      if (frame_err) err <= 1'b1;
      if (word_acc) begin
        cnt <= cnt + 9'd1;
        unique case (wr_fld)
          FLD_RC:  random_coin[wr_bit +: WORD_W] <= s_data;
          FLD_M:   m_in[wr_bit +: WORD_W]        <= s_data;
          FLD_PK:  pk_in[wr_bit +: WORD_W]       <= s_data;
          FLD_C:   c_in[wr_bit +: WORD_W]        <= s_data;
          FLD_SK:  sk_in[wr_bit +: WORD_W]       <= s_data;
          default: ;
        endcase
      end
`ifdef KYBER_LOADER_ZEROIZE_EN
      // Placed after the word write so the clear wins on the erroring word
      if (finish_acc) begin
        sk_in       <= '0;
        m_in        <= '0;
        random_coin <= '0;
      end
      if (frame_err) begin
        unique case (mode)
          2'd0: random_coin <= '0;
          2'd1: begin
            m_in <= '0;
            if (cnt >= ENC_RC) random_coin <= '0;
          end
          2'd2: if (cnt >= DEC_SK) sk_in <= '0;
          default: ;
        endcase
      end
`endif
    end
  end

endmodule

// File: tb/tb_kyber_io_loader.sv
// Directed self-checking bench for kyber_io_loader at WORD_W = 32.
module tb_kyber_io_loader;

  localparam int unsigned WORD_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready;
  logic [1:0]        cmd_mode;
  logic              s_valid, s_ready, s_last;
  logic [WORD_W-1:0] s_data;
  logic [1:0]        mode;
  logic              start, busy, done, err, core_finish;
  logic [255:0]      random_coin, m_in;
  logic [6399:0]     pk_in;
  logic [6143:0]     sk_in, c_in;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  int done_cnt  = 0;
  int saved_start, saved_done;

  kyber_io_loader #(.WORD_W(WORD_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_mode(cmd_mode), .cmd_ready(cmd_ready),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .mode(mode), .start(start),
    .random_coin(random_coin), .m_in(m_in), .pk_in(pk_in), .sk_in(sk_in), .c_in(c_in),
    .core_finish(core_finish), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (start) start_cnt++;
    if (done)  done_cnt++;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wdata(input int pat, input int k);
    case (pat)
      1:       return (k == 0) ? 32'h0000000F : 32'h0;
      2:       return 32'(k + 1000);
      3:       return 32'(k) ^ 32'hA5A50000;
      default: return 32'(k);
    endcase
  endfunction

  task automatic do_cmd(input logic [1:0] m);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Starts and ends on a negedge; ends one half-cycle after the last word is taken
  task automatic stream(input int n, input int last_idx, input int pat, input bit stall);
    for (int k = 0; k < n; k++) begin
      if (stall && k > 0) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        check("s_ready_stall", s_ready, 1);
      end
      s_valid = 1'b1;
      s_data  = wdata(pat, k);
      s_last  = (k == last_idx);
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic finish_core;
    core_finish = 1'b1;
    @(negedge clk);
    core_finish = 1'b0;
    check("done_pulse", done, 1);
    check("done_cmd_ready", cmd_ready, 1);
    check("done_busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'd0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; core_finish = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_start", start, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_mode", mode, 0);
    check("rst_rc", random_coin, 0);
    check("rst_pk_any", |pk_in, 0);

    core_finish = 1'b1;
    @(negedge clk);
    core_finish = 1'b0;
    @(negedge clk);
    check("finish_idle_ignored", done_cnt, 0);

    // Keygen
    do_cmd(2'd0);
    check("kg_s_ready", s_ready, 1);
    check("kg_cmd_ready", cmd_ready, 0);
    check("kg_busy", busy, 1);
    stream(8, 7, 1, 1'b0);
    check("kg_start", start, 1);
    @(negedge clk);
    check("kg_start_once", start, 0);
    check("kg_start_cnt", start_cnt, 1);
    check("kg_rc", random_coin, 256'h0F);
    check("kg_mode", mode, 0);
    finish_core();
`ifdef KYBER_LOADER_ZEROIZE_EN
    check("kg_rc_zeroized", random_coin, 0);
`endif
    @(negedge clk);
    check("kg_done_once", done_cnt, 1);

    // Encrypt, word k = k
    do_cmd(2'd1);
    stream(216, 215, 0, 1'b0);
    check("enc_start", start, 1);
    @(negedge clk);
    check("enc_mode", mode, 1);
    check("enc_m0", m_in[31:0], 0);
    check("enc_rc0", random_coin[31:0], 8);
    check("enc_pk0", pk_in[31:0], 16);
    check("enc_pk_top", pk_in[6399:6368], 215);
    finish_core();
    @(negedge clk);

    // Framing error: early s_last on word 100
    saved_start = start_cnt;
    do_cmd(2'd1);
    stream(100, 99, 2, 1'b0);
    check("ferr_err", err, 1);
    check("ferr_idle", cmd_ready, 1);
    check("ferr_busy", busy, 0);
    check("ferr_pk83", pk_in[83*32 +: 32], 1099);
    check("ferr_pk84_kept", pk_in[84*32 +: 32], 100);
    @(negedge clk);
    check("ferr_no_start", start_cnt, saved_start);

    do_cmd(2'd0);
    check("ferr_err_cleared", err, 0);
    stream(8, 7, 1, 1'b0);
    @(negedge clk);
    finish_core();
    @(negedge clk);

    // Missing s_last on the final word
    saved_start = start_cnt;
    do_cmd(2'd0);
    stream(8, 99, 1, 1'b0);
    check("nolast_err", err, 1);
    check("nolast_busy", busy, 0);
    @(negedge clk);
    check("nolast_no_start", start_cnt, saved_start);

    // Illegal mode
    do_cmd(2'd3);
    check("ill_err", err, 1);
    check("ill_s_ready", s_ready, 0);
    check("ill_busy", busy, 0);
    check("ill_mode", mode, 3);
    @(negedge clk);
    check("ill_s_ready_later", s_ready, 0);

    // Decrypt with a stalled stream
    saved_start = start_cnt;
    do_cmd(2'd2);
    check("dec_err_cleared", err, 0);
    stream(384, 383, 3, 1'b1);
    check("dec_start", start, 1);
    @(negedge clk);
    check("dec_start_cnt", start_cnt, saved_start + 1);
    check("dec_c0", c_in[31:0], 32'hA5A50000);
    check("dec_c_top", c_in[6143:6112], 32'hA5A500BF);
    check("dec_sk0", sk_in[31:0], 32'hA5A500C0);
    check("dec_sk_top", sk_in[6143:6112], 32'hA5A5017F);
    finish_core();
`ifdef KYBER_LOADER_ZEROIZE_EN
    check("dec_sk_zeroized", |sk_in, 0);
`else
    check("dec_sk_kept", sk_in[31:0], 32'hA5A500C0);
`endif
    check("dec_c_kept", c_in[31:0], 32'hA5A50000);
    @(negedge clk);

    // Reset while waiting for the core
    do_cmd(2'd0);
    stream(8, 7, 1, 1'b0);
    @(negedge clk);
    check("rw_busy_wait", busy, 1);
    saved_start = start_cnt;
    saved_done  = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    core_finish = 1'b1;
    @(negedge clk);
    core_finish = 1'b0;
    @(negedge clk);
    check("rw_no_done", done_cnt, saved_done);
    check("rw_no_start", start_cnt, saved_start);
    check("rw_done", done, 0);
    check("rw_busy", busy, 0);
    check("rw_cmd_ready", cmd_ready, 1);
    check("rw_s_ready", s_ready, 0);
    check("rw_err", err, 0);
    check("rw_mode", mode, 0);
    check("rw_rc", random_coin, 0);
    check("rw_sk_any", |sk_in, 0);
    check("rw_c_any", |c_in, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
